// File: rtl/bus_arbiter8way16.sv
// Round-robin arbiter sharing one registered WIDTH-bit output channel between 8 requesters,
// with optional bounded locked bursts for a single owner.
module bus_arbiter8way16 #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         req,
    input  logic [7:0]         lock,
    input  logic [8*WIDTH-1:0] in,
    input  logic               out_ready,
    output logic [7:0]         grant,
    output logic [2:0]         sel,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               busy
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] owner, owner_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] win;
    logic       cap;
    logic       slot;

    // First requester at or after p, wrapping mod 8; the lowest offset is written last and wins.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        rr_pick = p;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign slot = !out_valid || out_ready;
    assign busy = (state == OWN);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        win       = ptr;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (slot && |req) begin
                    cap = 1'b1;
                    win = rr_pick(req, ptr);
                    if (lock[win] && MAX_BURST > 1) begin
                        state_nxt = OWN;
                        owner_nxt = win;
                        cnt_nxt   = 4'd1;
                    end else begin
                        ptr_nxt = win + 3'd1;
                    end
                end
            end
            OWN: begin
                win = owner;
                // A dropped request ends the burst immediately, even while the output stalls.
                if (!req[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner + 3'd1;
                    cnt_nxt   = 4'd0;
                end else if (slot) begin
                    cap     = 1'b1;
                    cnt_nxt = cnt + 4'd1;
                    if (!lock[owner] || (cnt + 4'd1) == BURST_LIM) begin
                        state_nxt = IDLE;
                        ptr_nxt   = owner + 3'd1;
                        cnt_nxt   = 4'd0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) cap = 1'b0;
        grant = cap ? (8'b1 << win) : 8'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            owner     <= 3'd0;
            cnt       <= 4'd0;
            out       <= '0;
            sel       <= 3'd0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            if (cap) begin
                out       <= in[32'(win)*WIDTH +: WIDTH];
                sel       <= win;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter8way16.sv
// Randomized and directed bench for bus_arbiter8way16 against a queue-free behavioural model.
module tb_bus_arbiter8way16;

    localparam int WIDTH = 16;
    localparam int MAXB  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         req;
    logic [7:0]         lock;
    logic [8*WIDTH-1:0] in_bus;
    logic               out_ready;
    logic [7:0]         grant;
    logic [2:0]         sel;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    // Model: owner = -1 means nobody holds the channel.
    int               m_ptr, m_owner, m_cnt;
    logic [WIDTH-1:0] m_out;
    logic [2:0]       m_sel;
    logic             m_valid;

    bus_arbiter8way16 #(.WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .in(in_bus),
        .out_ready(out_ready), .grant(grant), .sel(sel), .out(out),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_grant();
        int idx;
        if (reset) return 8'h00;
        if (m_valid && !out_ready) return 8'h00;
        if (m_owner >= 0) return req[m_owner] ? 8'(1 << m_owner) : 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx = (m_ptr + k) % 8;
            if (req[idx]) return 8'(1 << idx);
        end
        return 8'h00;
    endfunction

    function automatic logic [WIDTH-1:0] word(input int i);
        return in_bus[i*WIDTH +: WIDTH];
    endfunction

    task automatic set_word(input int i, input logic [WIDTH-1:0] v);
        in_bus[i*WIDTH +: WIDTH] = v;
    endtask

    // Update the model from the inputs in force before the edge, then step past the edge.
    task automatic advance();
        logic [7:0] g;
        int w;
        g = model_grant();
        w = -1;
        for (int k = 0; k < 8; k++) if (g[k]) w = k;
        if (reset) begin
            m_ptr = 0; m_owner = -1; m_cnt = 0;
            m_out = '0; m_sel = 3'd0; m_valid = 1'b0;
        end else begin
            if (w >= 0) begin
                m_out = word(w); m_sel = 3'(w); m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_ptr = (m_owner + 1) % 8; m_owner = -1; m_cnt = 0;
                end else if (w >= 0) begin
                    m_cnt++;
                    if (!lock[m_owner] || m_cnt == MAXB) begin
                        m_ptr = (m_owner + 1) % 8; m_owner = -1; m_cnt = 0;
                    end
                end
            end else if (w >= 0) begin
                if (lock[w] && MAXB > 1) begin
                    m_owner = w; m_cnt = 1;
                end else begin
                    m_ptr = (w + 1) % 8;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; req = 8'h00; lock = 8'h00;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 8'hFF; lock = 8'hFF; out_ready = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h00) begin
            failures++; $display("FAIL reset_grant got=%h exp=00", grant);
        end
        advance();
        checks++;
        if ({out, out_valid, sel, busy} !== {16'h0000, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got out=%h v=%b sel=%0d busy=%b exp 0000/0/0/0",
                     out, out_valid, sel, busy);
        end
        reset = 1'b0; req = 8'h00; lock = 8'h00;
    endtask

    task automatic test_fairness();
        pulse_reset();
        for (int i = 0; i < 8; i++) set_word(i, 16'h1000 + 16'(i));
        req = 8'hFF; lock = 8'h00; out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            checks++;
            if (grant !== 8'(1 << (c % 8))) begin
                failures++; $display("FAIL rr_grant c=%0d got=%h exp=%h", c, grant, 8'(1 << (c % 8)));
            end
            advance();
            checks++;
            if ({out, sel, out_valid} !== {16'h1000 + 16'(c % 8), 3'(c % 8), 1'b1}) begin
                failures++;
                $display("FAIL rr_out c=%0d got out=%h sel=%0d v=%b exp out=%h sel=%0d v=1",
                         c, out, sel, out_valid, 16'h1000 + 16'(c % 8), c % 8);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_stall();
        pulse_reset();
        req = 8'h08; lock = 8'h00; out_ready = 1'b1; set_word(3, 16'hA5A3);
        #1;
        checks++;
        if (grant !== 8'h08) begin
            failures++; $display("FAIL stall_first_grant got=%h exp=08", grant);
        end
        advance();
        out_ready = 1'b0; set_word(3, 16'hB6B3);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (grant !== 8'h00) begin
                failures++; $display("FAIL stall_grant c=%0d got=%h exp=00", c, grant);
            end
            advance();
            checks++;
            if ({out, out_valid, sel} !== {16'hA5A3, 1'b1, 3'd3}) begin
                failures++;
                $display("FAIL stall_hold c=%0d got out=%h v=%b sel=%0d exp A5A3/1/3", c, out, out_valid, sel);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h08) begin
            failures++; $display("FAIL stall_release_grant got=%h exp=08", grant);
        end
        advance();
        checks++;
        if ({out, out_valid} !== {16'hB6B3, 1'b1}) begin
            failures++; $display("FAIL stall_next_word got out=%h v=%b exp B6B3/1", out, out_valid);
        end
        req = 8'h00;
        advance();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_lock_burst();
        pulse_reset();
        req = 8'h24; lock = 8'h04; out_ready = 1'b1; set_word(5, 16'h5555);
        for (int n = 0; n < 4; n++) begin
            set_word(2, 16'h2000 + 16'(n));
            #1;
            checks++;
            if (grant !== 8'h04) begin
                failures++; $display("FAIL burst_grant n=%0d got=%h exp=04", n, grant);
            end
            advance();
            checks++;
            if ({out, sel, busy} !== {16'h2000 + 16'(n), 3'd2, 1'(n < 3)}) begin
                failures++;
                $display("FAIL burst_word n=%0d got out=%h sel=%0d busy=%b exp out=%h sel=2 busy=%b",
                         n, out, sel, busy, 16'h2000 + 16'(n), n < 3);
            end
        end
        #1;
        checks++;
        if (grant !== 8'h20) begin
            failures++; $display("FAIL burst_after_grant got=%h exp=20", grant);
        end
        advance();
        checks++;
        if ({out, sel, busy} !== {16'h5555, 3'd5, 1'b0}) begin
            failures++; $display("FAIL burst_after_word got out=%h sel=%0d busy=%b exp 5555/5/0", out, sel, busy);
        end
        req = 8'h00; lock = 8'h00;
    endtask

    task automatic test_lock_drop();
        pulse_reset();
        req = 8'h24; lock = 8'h04; out_ready = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h04) begin
            failures++; $display("FAIL drop_grant0 got=%h exp=04", grant);
        end
        advance();
        lock = 8'h00;
        #1;
        checks++;
        if (grant !== 8'h04) begin
            failures++; $display("FAIL drop_grant1 got=%h exp=04", grant);
        end
        advance();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL drop_busy got=%b exp=0", busy);
        end
        #1;
        checks++;
        if (grant !== 8'h20) begin
            failures++; $display("FAIL drop_next_grant got=%h exp=20", grant);
        end
        advance();
        req = 8'h00;
    endtask

    task automatic test_owner_drop();
        pulse_reset();
        req = 8'h40; lock = 8'h40; out_ready = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h40) begin
            failures++; $display("FAIL odrop_grant got=%h exp=40", grant);
        end
        advance();
        req = 8'h02; lock = 8'h00;
        #1;
        checks++;
        if (grant !== 8'h00) begin
            failures++; $display("FAIL odrop_nogrant got=%h exp=00", grant);
        end
        advance();
        checks++;
        if ({busy, out_valid} !== 2'b00) begin
            failures++; $display("FAIL odrop_idle got busy=%b v=%b exp 0/0", busy, out_valid);
        end
        #1;
        checks++;
        if (grant !== 8'h02) begin
            failures++; $display("FAIL odrop_next_grant got=%h exp=02", grant);
        end
        advance();
        req = 8'h00;
    endtask

    task automatic test_reset_midburst();
        pulse_reset();
        req = 8'h10; lock = 8'h10; out_ready = 1'b1;
        advance();
        advance();
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h00) begin
            failures++; $display("FAIL midrst_grant got=%h exp=00", grant);
        end
        advance();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            failures++; $display("FAIL midrst_state got v=%b busy=%b exp 0/0", out_valid, busy);
        end
        reset = 1'b0; req = 8'h81; lock = 8'h00;
        #1;
        checks++;
        if (grant !== 8'h01) begin
            failures++; $display("FAIL midrst_first got=%h exp=01", grant);
        end
        advance();
        #1;
        checks++;
        if (grant !== 8'h80) begin
            failures++; $display("FAIL midrst_second got=%h exp=80", grant);
        end
        advance();
        req = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] eg;
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            req       = 8'($urandom) & 8'($urandom);
            lock      = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) set_word(i, 16'($urandom));
            #1;
            eg = model_grant();
            checks++;
            if (grant !== eg || !$onehot0(grant)) begin
                failures++; $display("FAIL rand_grant c=%0d got=%h exp=%h", c, grant, eg);
            end
            advance();
            checks++;
            if ({out, sel, out_valid, busy} !== {m_out, m_sel, m_valid, m_owner >= 0}) begin
                failures++;
                $display("FAIL rand_out c=%0d got out=%h sel=%0d v=%b busy=%b exp out=%h sel=%0d v=%b busy=%b",
                         c, out, sel, out_valid, busy, m_out, m_sel, m_valid, m_owner >= 0);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 8'h00; lock = 8'h00; in_bus = '0; out_ready = 1'b0;
        m_ptr = 0; m_owner = -1; m_cnt = 0; m_out = '0; m_sel = 3'd0; m_valid = 1'b0;
        test_reset();
        test_fairness();
        test_stall();
        test_lock_burst();
        test_lock_drop();
        test_owner_drop();
        test_reset_midburst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
